ahbextmem: RTL

AHB-Lite subordinate that models the external bus target of the SoC top level, replacing constant tie-offs (always-ready, OKAY, zero data) with a real byte-writable memory. Drives the `HRDATAEXT`/`HREADYEXT`/`HRESPEXT` return path of `wallypipelinedsoc` from its `HSELEXT`-qualified manager signals. Adds parametrised width and depth, programmable wait states, and an optional out-of-range ERROR response. Used in lint/sim wrappers and testbenches.

---
 rtl/ahbextmem_pkg.sv | 31 +++
 rtl/ahbextmem_if.sv | 39 +++
 rtl/ahbextmem_ram.sv | 43 ++++
 rtl/ahbextmem.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ahbextmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahbextmem_pkg
//  Purpose  : Shared definitions for the external AHB-Lite memory target:
//             HTRANS encodings, the subordinate FSM state type and a small
//             helper that decodes an active transfer.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ahbextmem_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahbextmem_state_t;

  // NONSEQ and SEQ both carry data; IDLE and BUSY never do.
  function automatic logic htrans_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahbextmem_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahbextmem_if
//  Purpose  : AHB-Lite manager/subordinate signal bundle for the external
//             bus target (HSELEXT-qualified request, EXT return path).
//  Ports    : master modport drives HSELEXT, HADDR, HTRANS, HWRITE, HSIZE,
//             HREADY, HWDATA, HWSTRB and receives HRDATAEXT, HREADYEXT,
//             HRESPEXT; slave modport is the mirror image.
//  Revision : 1.0 - initial release
// ============================================================================
interface ahbextmem_if #(
  parameter int DATA_BITS = 64,
  parameter int ADDR_BITS = 56
);

  logic                   HSELEXT;
  logic [ADDR_BITS-1:0]   HADDR;
  logic [1:0]             HTRANS;
  logic                   HWRITE;
  logic [2:0]             HSIZE;
  logic                   HREADY;
  logic [DATA_BITS-1:0]   HWDATA;
  logic [DATA_BITS/8-1:0] HWSTRB;
  logic [DATA_BITS-1:0]   HRDATAEXT;
  logic                   HREADYEXT;
  logic                   HRESPEXT;

  modport master (
    output HSELEXT, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, HWSTRB,
    input  HRDATAEXT, HREADYEXT, HRESPEXT
  );

  modport slave (
    input  HSELEXT, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, HWSTRB,
    output HRDATAEXT, HREADYEXT, HRESPEXT
  );

endinterface
`default_nettype wire

// File: rtl/ahbextmem_ram.sv
`default_nettype none
// ============================================================================
//  Module   : ahbextmem_ram
//  Purpose  : DEPTH x DATA_BITS flop array with per-byte write strobes and a
//             combinational read port. Contents are never reset.
//  Ports    : clk   - write clock
//             we    - write enable (commits on rising edge)
//             addr  - word index, shared by read and write
//             strb  - byte lane enables for the write
//             wdata - write data
//             rdata - combinational read of mem[addr]
//  Revision : 1.0 - initial release
// ============================================================================
module ahbextmem_ram #(
  parameter int DATA_BITS = 64,
  parameter int DEPTH     = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_BITS/8-1:0]   strb,
  input  logic [DATA_BITS-1:0]     wdata,
  output logic [DATA_BITS-1:0]     rdata
);

  localparam int BYTES = DATA_BITS / 8;

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (strb[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/ahbextmem.sv
`default_nettype none
// ============================================================================
//  Module   : ahbextmem
//  Purpose  : AHB-Lite subordinate modelling the SoC external bus target as a
//             byte-writable memory with programmable wait states.
//             Optional feature macro: AHBEXTMEM_ERROR_EN - when defined,
//             accesses outside [BASE_ADDR, BASE_ADDR + DEPTH*DATA_BITS/8)
//             receive a two-cycle ERROR response and do not touch memory;
//             when undefined the word index simply wraps modulo DEPTH.
//  Ports    : clk   - single clock, rising edge
//             reset - asynchronous, active-high
//             bus   - ahbextmem_if.slave (HSELEXT-qualified request in,
//                     HRDATAEXT/HREADYEXT/HRESPEXT out)
//  Revision : 1.0 - initial release
// ============================================================================
module ahbextmem
  import ahbextmem_pkg::*;
#(
  parameter int                   DATA_BITS   = 64,
  parameter int                   ADDR_BITS   = 56,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR   = '0,
  parameter int                   DEPTH       = 1024,
  parameter int                   WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       reset,
  ahbextmem_if.slave bus
);

  localparam int BYTES     = DATA_BITS / 8;
  localparam int LANE_BITS = $clog2(BYTES);
  localparam int IDX_BITS  = $clog2(DEPTH);
  localparam int WIN_LSB   = LANE_BITS + IDX_BITS;
  localparam int CNT_BITS  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  // The counter reaches zero on the last wait cycle, so it starts one short.
  localparam logic [CNT_BITS-1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? CNT_BITS'(WAIT_STATES - 1) : CNT_BITS'(0);

  ahbextmem_state_t     state, state_next;
  logic [IDX_BITS-1:0]  idx, idx_next;
  logic                 write_q;
  logic [CNT_BITS-1:0]  cnt, cnt_next;
  logic [ADDR_BITS-1:0] offset;
  logic                 in_range;
  logic                 ready_now;
  logic                 accept;
  logic                 load;
  logic                 ram_we;
  logic [DATA_BITS-1:0] ram_rdata;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  assign offset   = bus.HADDR - BASE_ADDR;
  assign idx_next = offset[WIN_LSB-1:LANE_BITS];

`ifdef AHBEXTMEM_ERROR_EN
  // BASE_ADDR is window-aligned, so a below-base address wraps to a large
  // offset; the explicit compare keeps the intent obvious anyway.
  assign in_range = (bus.HADDR >= BASE_ADDR) &&
                    (offset[ADDR_BITS-1:WIN_LSB] == '0);
  logic unused_bits;
  assign unused_bits = ^{offset[LANE_BITS-1:0], bus.HSIZE};
`else
  assign in_range = 1'b1;
  logic unused_bits;
  assign unused_bits = ^{offset[ADDR_BITS-1:WIN_LSB], offset[LANE_BITS-1:0],
                         bus.HSIZE};
`endif

  // Wait and first-error cycles hold HREADYEXT low; no new address phase can
  // complete while we stall the bus, so accepts are only honoured otherwise.
  assign ready_now = (state != ST_WAIT) && (state != ST_ERR1);
  assign accept    = bus.HSELEXT & bus.HREADY & htrans_active(bus.HTRANS) &
                     ready_now;

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        state_next = ST_IDLE;
        if (accept) begin
          load = 1'b1;
          if (!in_range) begin
            state_next = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_next = ST_WAIT;
            cnt_next   = CNT_LOAD;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_next = ST_DATA;
        end else begin
          cnt_next = cnt - CNT_BITS'(1);
        end
      end
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state and address-phase capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      write_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load) begin
        idx     <= idx_next;
        write_q <= bus.HWRITE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Memory and return path
  // --------------------------------------------------------------------------
  // Only an in-range transfer can reach DATA, so out-of-range writes never
  // commit and out-of-range reads return zero.
  assign ram_we = (state == ST_DATA) && write_q;

  ahbextmem_ram #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (idx),
    .strb  (bus.HWSTRB),
    .wdata (bus.HWDATA),
    .rdata (ram_rdata)
  );

  assign bus.HRDATAEXT = ((state == ST_DATA) && !write_q) ? ram_rdata : '0;
  assign bus.HREADYEXT = ready_now;
  assign bus.HRESPEXT  = (state == ST_ERR1) || (state == ST_ERR2);

endmodule
`default_nettype wire
